pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Match sequencer for the pong display datapath. Runs the game
//  phases IDLE -> SERVE -> PLAY -> POINT -> OVER and keeps both scores.
//  Gates ball/paddle animation via play_en and re-centres the ball via ball_reset.
//  Sits between the per-frame animate strobe and the ball/paddle update logic.
// PARAMETERS
//  WIN_SCORE     5   points needed to win; must be <= 2**SCORE_W-1
//  SCORE_W       4   width of each score counter
//  SERVE_FRAMES  60  frame ticks ball is held centred before play
//  POINT_FRAMES  90  frame ticks of freeze after a point is scored
// PORTS
//  clk         in   1        system clock (all logic on posedge)
//  reset       in   1        synchronous, active-high
//  frame_tick  in   1        one-clk pulse per frame (end of visible area)
//  start_btn   in   1        start/serve button, level, already synchronous
//  miss_left   in   1        ball touched left wall this frame; sampled on frame_tick only
//  miss_right  in   1        ball touched right wall this frame; sampled on frame_tick only
//  play_en     out  1        1 = datapath may move ball and paddles
//  ball_reset  out  1        1 = datapath holds ball at centre
//  serve_dir   out  1        initial ball direction; 0 = +x (right), 1 = -x (left)
//  score_p1    out  SCORE_W  left player score
//  score_p2    out  SCORE_W  right player score
//  winner      out  2        00 none, 01 p1, 10 p2
//  state       out  3        IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4 (PAUSE=5 if enabled)
// BEHAVIOUR
//  - Reset values: state=IDLE, play_en=0, ball_reset=1, serve_dir=0.
//    Reset values (cont.): scores=0, winner=00, frame counter=0, start edge register=0.
//  - Reset asserted in any state: all of the above on the next edge; it overrides every other input.
//  - start_edge = start_btn & ~start_q. start_q is registered every clk.
//  - All outputs are registered Moore decodes of state/scores.
//    Outputs change on the edge after the causing input is seen.
//  - IDLE: play_en=0, ball_reset=1. On start_edge -> SERVE; clear scores and counter.
//  - SERVE: ball_reset=1, play_en=0. The counter increments on frame_tick.
//    On the frame_tick where counter==SERVE_FRAMES-1: go to PLAY and clear the counter.
//  - PLAY: play_en=1, ball_reset=0. Act on frame_tick only; misses outside frame_tick are ignored.
//      miss_left only  -> score_p2+1, serve_dir<=0, go to POINT.
//      miss_right only -> score_p1+1, serve_dir<=1, go to POINT.
//      both set (corner) -> no score, serve_dir unchanged, go to SERVE.
//  - POINT: play_en=0, ball_reset=0, so the ball is frozen where it is.
//    Count frame_ticks. At counter==POINT_FRAMES-1:
//      if either score == WIN_SCORE -> OVER, with winner set to that player;
//      otherwise -> SERVE.
//  - OVER: play_en=0, ball_reset=1. Scores and winner are held.
//    On start_edge -> SERVE with scores=0, winner=00, serve_dir unchanged.
//  - Score arithmetic is unsigned SCORE_W-bit. A score never exceeds WIN_SCORE, so it never wraps.
//  - frame_tick coinciding with start_edge in IDLE/OVER: start_edge wins; the counter starts at 0.
//  - The counter width is clog2(max(SERVE_FRAMES,POINT_FRAMES)). It clears on every state change.
// CONFIGURATION
//  PONG_PAUSE_EN defined:
//    start_edge in PLAY -> PAUSE (state=5, play_en=0, ball_reset=0; ball and scores frozen).
//    start_edge in PAUSE -> PLAY.
//    Misses are ignored while in PAUSE.
//  PONG_PAUSE_EN undefined:
//    start_edge is ignored in PLAY. Code 5 is unreachable; any illegal state -> IDLE.
// TESTING
//  1 Reset, start_btn 0->1, then 60 frame_ticks -> SERVE for exactly 60 ticks, then PLAY with play_en=1.
//  2 PLAY, miss_right on frame_tick -> score_p1=1, serve_dir=1, POINT.
//    Then 90 ticks -> SERVE, ball_reset=1.
//  3 Score p2 five times -> after the 5th POINT window, state=OVER.
//    Expect winner=10, score_p2=5, play_en=0. Start edge -> scores 0, SERVE.
//  4 PLAY, miss_left+miss_right on the same frame_tick -> scores unchanged, state=SERVE.
//  5 PLAY, miss_left without frame_tick -> no change.
//    Reset mid-POINT -> IDLE, scores 0, next edge.
//  6 (PONG_PAUSE_EN) start edge in PLAY -> PAUSE, play_en=0.
//    miss_left during PAUSE -> ignored. Second start edge -> PLAY.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Match sequencer for the pong datapath: IDLE -> SERVE -> PLAY -> POINT -> OVER, with both scores.
// Optional pause phase in PLAY (state code 5) is built when PONG_PAUSE_EN is defined.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 5,
    parameter int SCORE_W      = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               play_en,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    logic [1:0]         winner_q, winner_d;
    logic               serve_dir_q, serve_dir_d;
    logic               play_en_q, play_en_d;
    logic               ball_reset_q, ball_reset_d;
    logic               start_q;
    logic               start_edge;
    logic               pause_req;

    assign start_edge = start_btn & ~start_q;

`ifdef PONG_PAUSE_EN
    assign pause_req = start_edge;
`else
    assign pause_req = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d  = ST_SERVE;
                    p1_d     = '0;
                    p2_d     = '0;
                    winner_d = 2'b00;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (pause_req) begin
                    state_d = ST_PAUSE;
                end else if (frame_tick) begin
                    // A corner hit touches both walls: nobody scores, just re-serve.
                    if (miss_left && miss_right) begin
                        state_d = ST_SERVE;
                    end else if (miss_left) begin
                        p2_d        = p2_q + SCORE_W'(1);
                        serve_dir_d = 1'b0;
                        state_d     = ST_POINT;
                    end else if (miss_right) begin
                        p1_d        = p1_q + SCORE_W'(1);
                        serve_dir_d = 1'b1;
                        state_d     = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (frame_tick) begin
                    if (cnt_q == POINT_LAST) begin
                        if (p1_q == WIN_VAL) begin
                            winner_d = 2'b01;
                            state_d  = ST_OVER;
                        end else if (p2_q == WIN_VAL) begin
                            winner_d = 2'b10;
                            state_d  = ST_OVER;
                        end else begin
                            state_d = ST_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    state_d  = ST_SERVE;
                    p1_d     = '0;
                    p2_d     = '0;
                    winner_d = 2'b00;
                end
            end
`ifdef PONG_PAUSE_EN
            ST_PAUSE: begin
                if (start_edge) begin
                    state_d = ST_PLAY;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every phase starts counting frames from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        play_en_d    = (state_d == ST_PLAY);
        ball_reset_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) || (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            winner_q     <= 2'b00;
            serve_dir_q  <= 1'b0;
            play_en_q    <= 1'b0;
            ball_reset_q <= 1'b1;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            play_en_q    <= play_en_d;
            ball_reset_q <= ball_reset_d;
            start_q      <= start_btn;
        end
    end

    assign play_en    = play_en_q;
    assign ball_reset = ball_reset_q;
    assign serve_dir  = serve_dir_q;
    assign score_p1   = p1_q;
    assign score_p2   = p2_q;
    assign winner     = winner_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed and randomized checks of pong_game_ctrl against a phase/tick-count reference model.
module tb_pong_game_ctrl;

    localparam int WIN_SCORE    = 5;
    localparam int SCORE_W      = 4;
    localparam int SERVE_FRAMES = 60;
    localparam int POINT_FRAMES = 90;

    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_POINT = 3;
    localparam int PH_OVER  = 4;
    localparam int PH_PAUSE = 5;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               frame_tick = 1'b0;
    logic               start_btn = 1'b0;
    logic               miss_left = 1'b0;
    logic               miss_right = 1'b0;
    logic               play_en;
    logic               ball_reset;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic [1:0]         winner;
    logic [2:0]         state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .WIN_SCORE   (WIN_SCORE),
        .SCORE_W     (SCORE_W),
        .SERVE_FRAMES(SERVE_FRAMES),
        .POINT_FRAMES(POINT_FRAMES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .start_btn (start_btn),
        .miss_left (miss_left),
        .miss_right(miss_right),
        .play_en   (play_en),
        .ball_reset(ball_reset),
        .serve_dir (serve_dir),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .winner    (winner),
        .state     (state)
    );

    // Reference model: current phase, how many frame ticks it has seen, scores, winner, serve side.
    int m_phase = PH_IDLE;
    int m_ticks = 0;
    int m_p1 = 0;
    int m_p2 = 0;
    int m_win = 0;
    int m_dir = 0;
    bit m_btn_prev = 1'b0;

    task automatic model_edge(input bit rst, input bit tick, input bit start,
                              input bit ml, input bit mr);
        bit pressed;
        int next_phase;
        pressed    = start && !m_btn_prev;
        m_btn_prev = start;
        if (rst) begin
            m_phase    = PH_IDLE;
            m_ticks    = 0;
            m_p1       = 0;
            m_p2       = 0;
            m_win      = 0;
            m_dir      = 0;
            m_btn_prev = 1'b0;
            return;
        end
        next_phase = m_phase;
        if (m_phase == PH_IDLE || m_phase == PH_OVER) begin
            if (pressed) begin
                next_phase = PH_SERVE;
                m_p1 = 0;
                m_p2 = 0;
                m_win = 0;
            end
        end else if (m_phase == PH_SERVE) begin
            if (tick) m_ticks++;
            if (m_ticks == SERVE_FRAMES) next_phase = PH_PLAY;
        end else if (m_phase == PH_PLAY) begin
`ifdef PONG_PAUSE_EN
            if (pressed) next_phase = PH_PAUSE;
            else
`endif
            if (tick && ml && mr) next_phase = PH_SERVE;
            else if (tick && ml) begin
                m_p2++;
                m_dir = 0;
                next_phase = PH_POINT;
            end else if (tick && mr) begin
                m_p1++;
                m_dir = 1;
                next_phase = PH_POINT;
            end
        end else if (m_phase == PH_POINT) begin
            if (tick) m_ticks++;
            if (m_ticks == POINT_FRAMES) begin
                if (m_p1 == WIN_SCORE) m_win = 1;
                else if (m_p2 == WIN_SCORE) m_win = 2;
                next_phase = (m_win != 0) ? PH_OVER : PH_SERVE;
            end
        end else if (m_phase == PH_PAUSE) begin
            if (pressed) next_phase = PH_PLAY;
        end
        if (next_phase != m_phase) m_ticks = 0;
        m_phase = next_phase;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_phase));
        chk("play_en", 32'(play_en), 32'(m_phase == PH_PLAY));
        chk("ball_reset", 32'(ball_reset),
            32'(m_phase == PH_IDLE || m_phase == PH_SERVE || m_phase == PH_OVER));
        chk("serve_dir", 32'(serve_dir), 32'(m_dir));
        chk("score_p1", 32'(score_p1), 32'(m_p1));
        chk("score_p2", 32'(score_p2), 32'(m_p2));
        chk("winner", 32'(winner), 32'(m_win));
    endtask

    task automatic step(input bit rst, input bit tick, input bit start,
                        input bit ml, input bit mr);
        reset      = rst;
        frame_tick = tick;
        start_btn  = start;
        miss_left  = ml;
        miss_right = mr;
        @(posedge clk);
        model_edge(rst, tick, start, ml, mr);
        #1;
        check_all();
    endtask

    // n frame ticks with random idle gaps between them.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bit lvl;
        // Reset, including reset overriding a simultaneous start press and tick.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ball_reset", 32'(ball_reset), 32'd1);
        chk("rst_play_en", 32'(play_en), 32'd0);

        // Start press -> SERVE for exactly SERVE_FRAMES ticks, then PLAY.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_to_serve", 32'(state), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_ticks(SERVE_FRAMES - 1);
        chk("serve_hold", 32'(state), 32'd1);
        run_ticks(1);
        chk("serve_to_play", 32'(state), 32'd2);
        chk("play_en_on", 32'(play_en), 32'd1);

        // Miss without a frame tick is ignored; miss_right on a tick scores p1.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("miss_no_tick", 32'(state), 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("p1_point_state", 32'(state), 32'd3);
        chk("p1_point_score", 32'(score_p1), 32'd1);
        chk("p1_point_dir", 32'(serve_dir), 32'd1);
        run_ticks(POINT_FRAMES - 1);
        chk("point_hold", 32'(state), 32'd3);
        chk("point_frozen", 32'(ball_reset), 32'd0);
        run_ticks(1);
        chk("point_to_serve", 32'(state), 32'd1);
        chk("serve_ball_reset", 32'(ball_reset), 32'd1);

        // Corner: both misses on one tick -> re-serve, scores unchanged.
        run_ticks(SERVE_FRAMES);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("corner_state", 32'(state), 32'd1);
        chk("corner_p1", 32'(score_p1), 32'd1);
        chk("corner_p2", 32'(score_p2), 32'd0);

        // p2 wins five points -> OVER.
        for (int k = 0; k < WIN_SCORE; k++) begin
            run_ticks(SERVE_FRAMES);
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            run_ticks(POINT_FRAMES);
        end
        chk("over_state", 32'(state), 32'd4);
        chk("over_winner", 32'(winner), 32'd2);
        chk("over_p2", 32'(score_p2), 32'd5);
        chk("over_play_en", 32'(play_en), 32'd0);

        // Start press coinciding with a tick in OVER: counter still starts at zero.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_p2", 32'(score_p2), 32'd0);
        chk("restart_winner", 32'(winner), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_ticks(SERVE_FRAMES - 1);
        chk("restart_serve_hold", 32'(state), 32'd1);
        run_ticks(1);
        chk("restart_play", 32'(state), 32'd2);

`ifdef PONG_PAUSE_EN
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_state", 32'(state), 32'd5);
        chk("pause_play_en", 32'(play_en), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("pause_miss_ignored", 32'(score_p2), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("unpause_state", 32'(state), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_in_play_ignored", 32'(state), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Reset in the middle of a POINT freeze.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_ticks(10);
        chk("pre_reset_point", 32'(state), 32'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_point_reset_state", 32'(state), 32'd0);
        chk("mid_point_reset_p2", 32'(score_p2), 32'd0);

        // Random play: start level toggles, sparse misses, occasional reset.
        lvl = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 39) == 0) lvl = ~lvl;
            step(($urandom_range(0, 1999) == 0), 1'($urandom_range(0, 1)), lvl,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
